// File: rtl/if_id_pipe.sv
// IF/ID pipeline boundary register with valid/ready flow control, synchronous flush
// and registered bubble outputs. Define IF_ID_SKID_EN to add a second (skid) entry.
module if_id_pipe #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
);

  logic              main_vld_q, main_vld_d;
  logic [ADDR_W-1:0] main_pc_q,  main_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d;
  logic              in_xfer, out_xfer, load_main;

  assign in_xfer   = if_valid && if_ready;
  assign out_xfer  = main_vld_q && id_ready;
  assign load_main = !main_vld_q || out_xfer;

  assign id_valid = main_vld_q;
  assign id_pc    = main_pc_q;
  assign id_inst  = main_inst_q;

`ifdef IF_ID_SKID_EN
  logic              skid_vld_q, skid_vld_d;
  logic [ADDR_W-1:0] skid_pc_q,  skid_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;

  // Ready is purely the registered "skid empty" flag: no path from id_ready.
  assign if_ready = !skid_vld_q;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_vld_d  = skid_vld_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if (flush) begin
      main_vld_d  = 1'b0;
      main_pc_d   = '0;
      main_inst_d = NOP_INST;
      skid_vld_d  = 1'b0;
    end else if (load_main) begin
      if (skid_vld_q) begin
        main_vld_d  = 1'b1;
        main_pc_d   = skid_pc_q;
        main_inst_d = skid_inst_q;
        skid_vld_d  = in_xfer;
        skid_pc_d   = if_pc;
        skid_inst_d = if_inst;
      end else if (in_xfer) begin
        main_vld_d  = 1'b1;
        main_pc_d   = if_pc;
        main_inst_d = if_inst;
      end else begin
        main_vld_d  = 1'b0;
        main_pc_d   = '0;
        main_inst_d = NOP_INST;
      end
    end else if (in_xfer) begin
      skid_vld_d  = 1'b1;
      skid_pc_d   = if_pc;
      skid_inst_d = if_inst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_vld_q  <= 1'b0;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
    end else begin
      skid_vld_q  <= skid_vld_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end
`else
  // Single entry: accept whenever the held beat is leaving or there is none.
  assign if_ready = id_ready || !main_vld_q;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    if (flush || (load_main && !in_xfer)) begin
      main_vld_d  = 1'b0;
      main_pc_d   = '0;
      main_inst_d = NOP_INST;
    end else if (load_main) begin
      main_vld_d  = 1'b1;
      main_pc_d   = if_pc;
      main_inst_d = if_inst;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_vld_q  <= 1'b0;
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
    end else begin
      main_vld_q  <= main_vld_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
    end
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed self-checking bench for if_id_pipe; covers both the single-entry build
// and the IF_ID_SKID_EN build.
module tb_if_id_pipe;
  localparam int          ADDR_W = 32;
  localparam int          INST_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_valid, if_ready, flush, id_valid, id_ready;
  logic [ADDR_W-1:0] if_pc, id_pc;
  logic [INST_W-1:0] if_inst, id_inst;

  int checks = 0;
  int errors = 0;

  if_id_pipe #(.ADDR_W(ADDR_W), .INST_W(INST_W), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .flush(flush), .id_valid(id_valid),
    .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, $urandom);
      id_ready = 1'($urandom_range(0, 1));
      flush    = 1'($urandom_range(0, 1));
      tick();
    end
    flush = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", id_valid); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", id_pc); end
    checks++; if (id_inst !== NOP) begin errors++; $display("FAIL reset_inst got %h want %h", id_inst, NOP); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %0b want 1", if_ready); end
    rst = 1'b1;
    id_ready = 1'b0;
    drive(1'b1, 32'h100, 32'h2008_0005);
    tick();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %0b want 1", id_valid); end
    checks++; if (id_pc !== 32'h100) begin errors++; $display("FAIL first_pc got %h want 100", id_pc); end
    checks++; if (id_inst !== 32'h2008_0005) begin errors++; $display("FAIL first_inst got %h want 20080005", id_inst); end
    drive(1'b0, 32'h0, 32'h0);
    id_ready = 1'b1;
    tick();
    checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== NOP) begin
      errors++; $display("FAIL drain_bubble got v=%0b pc=%h inst=%h want v=0 pc=0 inst=%h", id_valid, id_pc, id_inst, NOP);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pcs [4];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8; pcs[3] = 32'hC;
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, pcs[i], 32'hA000_0000 | pcs[i]);
      tick();
      checks++; if (id_valid !== 1'b1 || id_pc !== pcs[i] || id_inst !== (32'hA000_0000 | pcs[i])) begin
        errors++; $display("FAIL stream_%0d got v=%0b pc=%h inst=%h want v=1 pc=%h", i, id_valid, id_pc, id_inst, pcs[i]);
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stream_end got %0b want 0", id_valid); end
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0;
    drive(1'b1, 32'h0, 32'h1111_0000);
    tick();
    checks++; if (id_pc !== 32'h0 || id_valid !== 1'b1) begin errors++; $display("FAIL bp_first got v=%0b pc=%h want v=1 pc=0", id_valid, id_pc); end
`ifdef IF_ID_SKID_EN
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %0b want 1", if_ready); end
    drive(1'b1, 32'h4, 32'h1111_0004);
    tick();
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL bp_hold got %h want 0", id_pc); end
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_two got %0b want 0", if_ready); end
    drive(1'b0, 32'h0, 32'h0);
    id_ready = 1'b1;
    tick();
    checks++; if (id_pc !== 32'h4 || id_inst !== 32'h1111_0004 || id_valid !== 1'b1) begin
      errors++; $display("FAIL bp_second got v=%0b pc=%h inst=%h want v=1 pc=4 inst=11110004", id_valid, id_pc, id_inst);
    end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %0b want 1", if_ready); end
`else
    drive(1'b1, 32'h4, 32'h1111_0004);
    #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL ns_ready_low got %0b want 0", if_ready); end
    tick();
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL ns_hold got %h want 0", id_pc); end
    id_ready = 1'b1;
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL ns_ready_comb got %0b want 1", if_ready); end
    tick();
    checks++; if (id_pc !== 32'h4 || id_inst !== 32'h1111_0004) begin
      errors++; $display("FAIL ns_second got pc=%h inst=%h want pc=4 inst=11110004", id_pc, id_inst);
    end
    drive(1'b0, 32'h0, 32'h0);
`endif
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %0b want 0", id_valid); end
  endtask

  task automatic test_flush();
    id_ready = 1'b0;
    drive(1'b1, 32'h10, 32'h2222_0010);
    tick();
`ifdef IF_ID_SKID_EN
    drive(1'b1, 32'h14, 32'h2222_0014);
    tick();
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL flush_setup got if_ready=%0b want 0", if_ready); end
`endif
    drive(1'b1, 32'h8, 32'h2222_0008);
    flush = 1'b1;
    id_ready = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== NOP) begin
      errors++; $display("FAIL flush_bubble got v=%0b pc=%h inst=%h want v=0 pc=0 inst=%h", id_valid, id_pc, id_inst, NOP);
    end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b want 1", if_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_no_leak_%0d got v=%0b pc=%h want v=0", i, id_valid, id_pc); end
    end
  endtask

  task automatic test_async_reset();
    id_ready = 1'b0;
    drive(1'b1, 32'h40, 32'h3333_0040);
    tick();
`ifdef IF_ID_SKID_EN
    drive(1'b1, 32'h44, 32'h3333_0044);
    tick();
`endif
    drive(1'b0, 32'h0, 32'h0);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin errors++; $display("FAIL ar_setup got v=%0b pc=%h want v=1 pc=40", id_valid, id_pc); end
    rst = 1'b0;
    #2;
    checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== NOP || if_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset got v=%0b pc=%h inst=%h rdy=%0b want v=0 pc=0 inst=%h rdy=1", id_valid, id_pc, id_inst, if_ready, NOP);
    end
    tick();
    rst = 1'b1;
    id_ready = 1'b1;
    drive(1'b1, 32'h200, 32'h4444_0200);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_inst !== 32'h4444_0200) begin
      errors++; $display("FAIL ar_first_accept got v=%0b pc=%h inst=%h want v=1 pc=200", id_valid, id_pc, id_inst);
    end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL ar_leftover got v=%0b pc=%h want v=0", id_valid, id_pc); end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; id_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
